bmem_arbiter: RTL and testbench

Two-port cache-line arbiter that shares the single burst-memory interface between the instruction cache (read-only) and the data cache (read/write). Each granted 256-bit line request is serialized into a 4-beat, 64-bit burst on the memory side, and the read beats are reassembled into a full line. The arbiter sits between the two L1 caches and the burst memory model.

---
 rtl/bmem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_bmem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bmem_arbiter.sv
// bmem_arbiter: shares one burst-memory port between the I-cache (read-only)
// and the D-cache (read/write). A granted 256-bit line request becomes a
// BURST_LEN-beat burst of BUS_WIDTH-bit beats; read beats are reassembled
// into a full line that is returned with a one-cycle resp pulse.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   imem_*            I-cache line read request / returned line / resp pulse
//   dmem_*            D-cache line read/write request / returned line / resp
//   bmem_*            burst memory: line-aligned address, read/write strobes,
//                     write beat out, read beat in, per-beat resp in
//   err               sticky protocol-error flag, cleared only by reset
module bmem_arbiter #(
   parameter int unsigned LINE_WIDTH = 256,
   parameter int unsigned BUS_WIDTH  = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           imem_addr,
   input  logic                  imem_read,
   output logic [LINE_WIDTH-1:0] imem_rdata,
   output logic                  imem_resp,
   input  logic [31:0]           dmem_addr,
   input  logic                  dmem_read,
   input  logic                  dmem_write,
   input  logic [LINE_WIDTH-1:0] dmem_wdata,
   output logic [LINE_WIDTH-1:0] dmem_rdata,
   output logic                  dmem_resp,
   output logic [31:0]           bmem_addr,
   output logic                  bmem_read,
   output logic                  bmem_write,
   output logic [BUS_WIDTH-1:0]  bmem_wdata,
   input  logic [BUS_WIDTH-1:0]  bmem_rdata,
   input  logic                  bmem_resp,
   output logic                  err
);

   localparam int unsigned BURST_LEN = LINE_WIDTH / BUS_WIDTH;
   localparam int unsigned CNT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int unsigned OFFSET_W  = $clog2(LINE_WIDTH / 8);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RD_BURST = 2'd1,
      WR_BURST = 2'd2,
      DONE     = 2'd3
   } state_t;

   typedef logic [CNT_W-1:0]                    beat_t;
   typedef logic [BURST_LEN-1:0][BUS_WIDTH-1:0] line_t;

   state_t state;
   beat_t  cnt;
   logic   last_d;      // last grant went to D (round-robin pointer)
   logic   src_d;       // current burst belongs to D
   line_t  line_q;      // write line latch / read assembly buffer

   logic        d_conflict_c;
   logic        req_i_c;
   logic        req_d_c;
   logic        grant_d_c;
   logic        last_beat_c;
   logic [31:0] grant_addr_c;
   line_t       asm_line_c;

   // Request decode and round-robin choice; a read+write D request is illegal
   // and is treated as no request.
   always_comb begin
      d_conflict_c = dmem_read & dmem_write;
      req_i_c      = imem_read;
      req_d_c      = (dmem_read | dmem_write) & ~d_conflict_c;
      grant_d_c    = req_d_c & (~req_i_c | ~last_d);
      grant_addr_c = grant_d_c ? dmem_addr : imem_addr;
      last_beat_c  = (cnt == beat_t'(BURST_LEN - 1));
   end

   // Line as it will look once the beat on bmem_rdata is captured.
   always_comb begin
      asm_line_c      = line_q;
      asm_line_c[cnt] = bmem_rdata;
   end

   // Arbitration / burst FSM with registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= '0;
         last_d     <= 1'b1;
         src_d      <= 1'b0;
         line_q     <= '0;
         imem_rdata <= '0;
         imem_resp  <= 1'b0;
         dmem_rdata <= '0;
         dmem_resp  <= 1'b0;
         bmem_addr  <= '0;
         bmem_read  <= 1'b0;
         bmem_write <= 1'b0;
         bmem_wdata <= '0;
         err        <= 1'b0;
      end else begin
         imem_resp <= 1'b0;
         dmem_resp <= 1'b0;
         case (state)
            IDLE: begin
               if (bmem_resp || d_conflict_c) begin
                  err <= 1'b1;
               end
               if (req_i_c || req_d_c) begin
                  cnt       <= '0;
                  last_d    <= grant_d_c;
                  src_d     <= grant_d_c;
                  bmem_addr <= {grant_addr_c[31:OFFSET_W], OFFSET_W'(0)};
                  if (grant_d_c && dmem_write) begin
                     state      <= WR_BURST;
                     bmem_write <= 1'b1;
                     line_q     <= dmem_wdata;
                     bmem_wdata <= dmem_wdata[BUS_WIDTH-1:0];
                  end else begin
                     state     <= RD_BURST;
                     bmem_read <= 1'b1;
                  end
               end
            end

            RD_BURST: begin
               if (bmem_resp) begin
                  line_q[cnt] <= bmem_rdata;
                  cnt         <= cnt + 1'b1;
                  if (last_beat_c) begin
                     state     <= DONE;
                     bmem_read <= 1'b0;
                     if (src_d) begin
                        dmem_rdata <= asm_line_c;
                        dmem_resp  <= 1'b1;
                     end else begin
                        imem_rdata <= asm_line_c;
                        imem_resp  <= 1'b1;
                     end
                  end
               end
            end

            WR_BURST: begin
               // Advance the beat on the edge the memory samples the current one.
               if (bmem_resp) begin
                  cnt        <= cnt + 1'b1;
                  bmem_wdata <= line_q[beat_t'(cnt + 1'b1)];
                  if (last_beat_c) begin
                     state      <= DONE;
                     bmem_write <= 1'b0;
                     dmem_resp  <= 1'b1;
                  end
               end
            end

            DONE: begin
               if (bmem_resp) begin
                  err <= 1'b1;
               end
               state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bmem_arbiter.sv
// Directed testbench for bmem_arbiter with a reactive burst-memory model and
// a scoreboard of expected line responses.
module tb_bmem_arbiter;

   localparam int unsigned LW = 256;
   localparam int unsigned BW = 64;

   logic          clk = 1'b0;
   logic          rst;
   logic [31:0]   imem_addr;
   logic          imem_read;
   logic [LW-1:0] imem_rdata;
   logic          imem_resp;
   logic [31:0]   dmem_addr;
   logic          dmem_read;
   logic          dmem_write;
   logic [LW-1:0] dmem_wdata;
   logic [LW-1:0] dmem_rdata;
   logic          dmem_resp;
   logic [31:0]   bmem_addr;
   logic          bmem_read;
   logic          bmem_write;
   logic [BW-1:0] bmem_wdata;
   logic [BW-1:0] bmem_rdata;
   logic          bmem_resp;
   logic          err;

   bmem_arbiter #(.LINE_WIDTH(LW), .BUS_WIDTH(BW)) dut (
      .clk(clk), .rst(rst),
      .imem_addr(imem_addr), .imem_read(imem_read),
      .imem_rdata(imem_rdata), .imem_resp(imem_resp),
      .dmem_addr(dmem_addr), .dmem_read(dmem_read), .dmem_write(dmem_write),
      .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
      .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
      .bmem_wdata(bmem_wdata), .bmem_rdata(bmem_rdata), .bmem_resp(bmem_resp),
      .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit            side_d;
      bit            is_read;
      logic [LW-1:0] line;
   } exp_t;

   exp_t        sb[$];
   logic [63:0] mem [logic [31:0]];
   int          mk = 0;
   bit          stall = 1'b0;
   bit          tog = 1'b0;
   bit          force_resp = 1'b0;
   int          tests = 0;
   int          fails = 0;

   task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] mem_word(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return {a, a ^ 32'hA5A5_5A5A};
   endfunction

   function automatic logic [LW-1:0] exp_line(input logic [31:0] a);
      logic [31:0] b;
      b = a & ~32'h1F;
      return {mem_word(b + 32'd24), mem_word(b + 32'd16), mem_word(b + 32'd8), mem_word(b)};
   endfunction

   // Memory model: accepts a beat on each edge with resp high.
   always @(posedge clk) begin
      if (!rst) begin
         mk = 0;
      end else if (bmem_resp && (bmem_read || bmem_write)) begin
         if (bmem_write) mem[bmem_addr + 32'(8 * mk)] = bmem_wdata;
         mk = (mk + 1) % 4;
      end
   end

   // Memory model: drives resp/rdata away from the active edge.
   always @(negedge clk) begin
      tog        = ~tog;
      bmem_resp  = force_resp || ((bmem_read || bmem_write) && !(stall && tog));
      bmem_rdata = mem_word(bmem_addr + 32'(8 * mk));
   end

   // Response monitor: each resp pulse must match the head of the scoreboard.
   always @(negedge clk) begin : mon
      exp_t e;
      if (rst && (imem_resp || dmem_resp)) begin
         if (sb.size() == 0) begin
            check("resp_unexpected", LW'(1), LW'(0));
         end else begin
            e = sb.pop_front();
            check("resp_side", LW'({imem_resp, dmem_resp}), LW'(e.side_d ? 2'b01 : 2'b10));
            if (e.is_read) check("resp_rdata", e.side_d ? dmem_rdata : imem_rdata, e.line);
         end
      end
   end

   task automatic push(input bit side_d, input bit is_read, input logic [31:0] addr);
      exp_t e;
      e.side_d  = side_d;
      e.is_read = is_read;
      e.line    = is_read ? exp_line(addr) : '0;
      sb.push_back(e);
   endtask

   task automatic wait_resp(input bit side_d);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(side_d ? dmem_resp : imem_resp) && n < 300);
      check(side_d ? "resp_d_seen" : "resp_i_seen", LW'(side_d ? dmem_resp : imem_resp), LW'(1));
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      int n;
      int pushed;
      rst = 1'b0; imem_addr = '0; imem_read = 1'b0;
      dmem_addr = '0; dmem_read = 1'b0; dmem_write = 1'b0; dmem_wdata = '0;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_imem_rdata", imem_rdata, LW'(0));
      check("rst_dmem_rdata", dmem_rdata, LW'(0));
      check("rst_resp", LW'({imem_resp, dmem_resp}), LW'(0));
      check("rst_bmem_addr", LW'(bmem_addr), LW'(0));
      check("rst_bmem_rw", LW'({bmem_read, bmem_write}), LW'(0));
      check("rst_bmem_wdata", LW'(bmem_wdata), LW'(0));
      check("rst_err", LW'(err), LW'(0));
      rst = 1'b1;
      @(negedge clk);

      // I read with aligned address and known beats
      mem[32'h1220] = 64'h1111_1111_1111_1111;
      mem[32'h1228] = 64'h2222_2222_2222_2222;
      mem[32'h1230] = 64'h3333_3333_3333_3333;
      mem[32'h1238] = 64'h4444_4444_4444_4444;
      imem_addr = 32'h0000_1234; imem_read = 1'b1;
      push(1'b0, 1'b1, 32'h0000_1234);
      @(posedge clk); #1;
      check("i_bmem_read", LW'(bmem_read), LW'(1));
      check("i_bmem_addr", LW'(bmem_addr), LW'(32'h0000_1220));
      wait_resp(1'b0);
      check("i_read_drop", LW'(bmem_read), LW'(0));
      check("i_line", imem_rdata, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                   64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
      imem_read = 1'b0;
      @(negedge clk);

      // D write of four distinct beats
      dmem_addr  = 32'h0000_0040;
      dmem_wdata = {64'hDDDD_0000_0000_0004, 64'hCCCC_0000_0000_0003,
                    64'hBBBB_0000_0000_0002, 64'hAAAA_0000_0000_0001};
      dmem_write = 1'b1;
      push(1'b1, 1'b0, 32'h0000_0040);
      wait_resp(1'b1);
      check("w_write_drop", LW'(bmem_write), LW'(0));
      dmem_write = 1'b0;
      check("w_mem40", LW'(mem_word(32'h40)), LW'(64'hAAAA_0000_0000_0001));
      check("w_mem48", LW'(mem_word(32'h48)), LW'(64'hBBBB_0000_0000_0002));
      check("w_mem50", LW'(mem_word(32'h50)), LW'(64'hCCCC_0000_0000_0003));
      check("w_mem58", LW'(mem_word(32'h58)), LW'(64'hDDDD_0000_0000_0004));
      @(negedge clk);

      // D read-back of the written line with resp gaps
      stall = 1'b1;
      dmem_addr = 32'h0000_0048; dmem_read = 1'b1;
      push(1'b1, 1'b1, 32'h0000_0048);
      wait_resp(1'b1);
      check("d_readback", dmem_rdata, {64'hDDDD_0000_0000_0004, 64'hCCCC_0000_0000_0003,
                                       64'hBBBB_0000_0000_0002, 64'hAAAA_0000_0000_0001});
      dmem_read = 1'b0;
      stall = 1'b0;

      // Conflicts: out of reset I wins, again I, then after a lone I grant D wins
      pulse_reset();
      for (int c = 0; c < 3; c++) begin
         if (c == 2) begin
            imem_addr = 32'h0000_0300; imem_read = 1'b1;
            push(1'b0, 1'b1, 32'h0000_0300);
            wait_resp(1'b0);
            imem_read = 1'b0;
            @(negedge clk);
         end
         imem_addr = 32'h0000_0100 + 32'(c * 32'h1000);
         dmem_addr = 32'h0000_0200 + 32'(c * 32'h1000);
         imem_read = 1'b1; dmem_read = 1'b1;
         if (c < 2) begin
            push(1'b0, 1'b1, imem_addr); push(1'b1, 1'b1, dmem_addr);
            wait_resp(1'b0); imem_read = 1'b0;
            wait_resp(1'b1); dmem_read = 1'b0;
         end else begin
            push(1'b1, 1'b1, dmem_addr); push(1'b0, 1'b1, imem_addr);
            wait_resp(1'b1); dmem_read = 1'b0;
            wait_resp(1'b0); imem_read = 1'b0;
         end
         @(negedge clk);
      end

      // Back-to-back D with I pending: grants alternate D, I, D, I
      dmem_addr = 32'h0000_4000; imem_addr = 32'h0000_5000;
      dmem_read = 1'b1; imem_read = 1'b1;
      push(1'b1, 1'b1, dmem_addr); push(1'b0, 1'b1, imem_addr);
      pushed = 2;
      for (int k = 0; k < 4; k++) begin
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!(imem_resp || dmem_resp) && n < 300);
         check("alt_side", LW'({imem_resp, dmem_resp}), LW'((k % 2 == 0) ? 2'b01 : 2'b10));
         if (dmem_resp) dmem_read = 1'b0;
         else imem_read = 1'b0;
         @(negedge clk);
         if (pushed < 4) begin
            if (k % 2 == 0) begin
               dmem_addr = dmem_addr + 32'h20; dmem_read = 1'b1;
               push(1'b1, 1'b1, dmem_addr);
            end else begin
               imem_addr = imem_addr + 32'h20; imem_read = 1'b1;
               push(1'b0, 1'b1, imem_addr);
            end
            pushed++;
         end
      end
      check("normal_err", LW'(err), LW'(0));

      // Reset in the middle of a read burst, request held through reset
      imem_addr = 32'h0000_2040; imem_read = 1'b1;
      push(1'b0, 1'b1, 32'h0000_2040);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(bmem_read && mk == 2) && n < 300);
      check("mid_reached", LW'(bmem_read), LW'(1));
      #2 rst = 1'b0;
      #1;
      check("mid_read_drop", LW'(bmem_read), LW'(0));
      check("mid_no_resp", LW'(imem_resp), LW'(0));
      check("mid_rdata_clr", imem_rdata, LW'(0));
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      wait_resp(1'b0);
      imem_read = 1'b0;
      @(negedge clk);

      // Illegal D read+write: flagged, no bus activity, sticky until reset
      dmem_addr = 32'h0000_0600; dmem_read = 1'b1; dmem_write = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("rw_no_bus", LW'({bmem_read, bmem_write}), LW'(0));
      end
      check("rw_err", LW'(err), LW'(1));
      dmem_read = 1'b0; dmem_write = 1'b0;
      repeat (3) @(negedge clk);
      check("rw_err_sticky", LW'(err), LW'(1));
      pulse_reset();
      check("err_cleared", LW'(err), LW'(0));

      // Spurious bmem_resp while idle
      #1 force_resp = 1'b1;
      @(negedge clk);
      #1 force_resp = 1'b0;
      @(posedge clk); #1;
      check("spurious_err", LW'(err), LW'(1));
      repeat (2) @(negedge clk);

      check("sb_drained", LW'(sb.size()), LW'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
